branch_target_ctrl: RTL and testbench
=====================================

BRANCH_TARGET_CTRL -- requirements
Module: branch_target_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of outstanding unresolved B-type branches tracked (power of two, ≥2).
REQ-002 SHALL have parameter W, default `data_size (32), meaning the PC/target width.
REQ-003 SHALL provide these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  OR of Istall, Dstall and wfi_stall; freezes the block.
- push_valid  in  1  B-type fetched in IF.
- push_pred_taken  in  1  prediction used at fetch.
- push_alt_target  in  W  PC to use if the prediction is wrong.
- resolve_valid  in  1  oldest branch resolves in EX.
- resolve_taken  in  1  actual outcome.
- push_ready  out  1  push can be accepted this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  occupancy.
- redirect_valid  out  1  PC mux must load redirect_pc.
- redirect_pc  out  W  corrected fetch PC.
- flush_if  out  1  kill the IF/ID register.
- flush_id  out  1  kill the ID/EX register.
- err_underflow  out  1  sticky; a resolve arrived with the FIFO empty.

Function
REQ-004 SHALL hold entries {pred_taken, alt_target} in a circular FIFO with rd_ptr/wr_ptr wrapping modulo DEPTH.
REQ-005 push_ready SHALL equal (state==RUN) && !full && !stall.
REQ-006 A push SHALL be accepted iff push_valid && push_ready; it writes at wr_ptr, and wr_ptr and count update at the next edge.
REQ-007 A pop SHALL occur iff resolve_valid && !stall && !empty && state==RUN.
REQ-008 When full, a simultaneous push and pop SHALL still refuse the push, because push_ready is evaluated before the pop; count decrements by 1.
REQ-009 When neither full nor empty, a simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-010 A mispredict SHALL be defined as a pop where resolve_taken != head.pred_taken.
REQ-011 A correct prediction SHALL only pop: no redirect and no flush.
REQ-012 On a mispredict at edge N, the block SHALL:
- drive redirect_valid=1 and redirect_pc=head.alt_target during cycle N+1;
- clear the FIFO (pointers and count = 0, any same-cycle push discarded);
- enter state FLUSH1.
REQ-013 The state machine SHALL have states RUN, FLUSH1 and FLUSH2:
- RUN to FLUSH1 on a mispredict;
- FLUSH1 to FLUSH2 on a non-stalled cycle;
- FLUSH2 to RUN on a non-stalled cycle.
REQ-014 flush_if and flush_id SHALL be registered and high exactly while the state is FLUSH1 or FLUSH2.
REQ-015 redirect_valid SHALL be a one-non-stalled-cycle pulse; if stall is high in cycle N+1, redirect_valid and redirect_pc SHALL hold until the first cycle with stall low, then drop.
REQ-016 While stall=1, the state, pointers, count, FIFO contents and outputs SHALL not change, except err_underflow, which may still set.
REQ-017 A resolve_valid with empty=1 (and no stall) SHALL be ignored and SHALL set err_underflow, which stays set until reset.
REQ-018 resolve_valid and push_valid received in FLUSH1 or FLUSH2 SHALL be ignored and SHALL NOT set err_underflow.
REQ-019 No output SHALL depend combinationally on resolve_* or push_* except push_ready, which depends on stall.

Reset
REQ-020 When rst is low, the block SHALL asynchronously force:
- state RUN, pointers 0, count 0, empty 1, full 0;
- redirect_valid 0, redirect_pc 0;
- flush_if 0, flush_id 0, err_underflow 0.
REQ-021 A reset asserted mid-FLUSH SHALL abort the flush with no further redirect pulse; operation SHALL resume in RUN at the first clk edge after rst deasserts.
REQ-022 FIFO payload storage SHALL need no reset; entries SHALL be valid only as indicated by count.

Structure
REQ-023 A shared package (bq_pkg) SHALL hold the state enum {RUN, FLUSH1, FLUSH2}, the entry struct {pred_taken, alt_target}, and the DEPTH default; W SHALL come from `data_size in define.sv.
REQ-024 The FIFO storage and pointer logic SHALL be a sub-module, bq_fifo, with push, pop, clear and stall inputs; the FSM and redirect logic SHALL stay in branch_target_ctrl.

Verification
REQ-025 Push (pred 0, alt 0x100) then (pred 1, alt 0x200), then push_valid again -> full=1 and push_ready=0; the third entry is not stored and count=2.
REQ-026 With 2 entries, resolve_taken=1 against head pred 0 -> cycle N+1 has redirect_valid=1 and redirect_pc=0x100; flush_if and flush_id are high for 2 cycles; count=0; state returns to RUN.
REQ-027 With 1 entry, push and resolve (correct) in the same cycle -> count stays 1, no redirect, and wr_ptr wraps from 1 to 0.
REQ-028 Mispredict with stall=1 for 3 cycles at N+1 -> redirect_valid is held with 0x100 through the stall and drops 1 cycle after stall falls; FLUSH timing starts only after that.
REQ-029 resolve_valid with empty=1 -> err_underflow=1 and stays 1 until rst is low; count stays 0.
REQ-030 rst low during FLUSH1 -> all outputs are 0 and empty=1 immediately (asynchronously); after release the next push is accepted.

Source files
------------

// File: rtl/bq_pkg.sv
// bq_pkg: shared types for the branch target queue
`include "define.sv"
package bq_pkg;
    localparam int DEPTH_DEF = 2;
    localparam int W_DEF = `DATA_SIZE;
    typedef enum logic [1:0] {RUN, FLUSH1, FLUSH2} state_e;
    typedef struct packed {
        logic             pred_taken;
        logic [W_DEF-1:0] alt_target;
    } entry_t;
endpackage

// File: rtl/bq_fifo.sv
// bq_fifo: circular FIFO of unresolved branches; clear wins over push/pop, stall freezes
module bq_fifo
    import bq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  entry_t        push_entry,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    entry_t        mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        rd_ptr_d = stall ? rd_ptr_q : clear ? '0 : rd_ptr_q + PW'(pop);
        wr_ptr_d = stall ? wr_ptr_q : clear ? '0 : wr_ptr_q + PW'(push);
        count_d  = stall ? count_q  : clear ? '0 : count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
    // payload is qualified by count, so it carries no reset
    always_ff @(posedge clk)
        if (push && !stall && !clear) mem_q[wr_ptr_q] <= push_entry;
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = count_q == '0;
    assign full  = count_q == CW'(DEPTH);
endmodule

// File: rtl/define.sv
// define.sv: global datapath width shared by the pipeline
`ifndef DEFINE_SV
`define DEFINE_SV
`define DATA_SIZE 32
`endif

// File: rtl/branch_target_ctrl.sv
// branch_target_ctrl: tracks in-flight B-type predictions and issues redirect/flush on a mispredict
module branch_target_ctrl
    import bq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W = W_DEF,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          push_valid,
    input  logic          push_pred_taken,
    input  logic [W-1:0]  push_alt_target,
    input  logic          resolve_valid,
    input  logic          resolve_taken,
    output logic          push_ready,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          redirect_valid,
    output logic [W-1:0]  redirect_pc,
    output logic          flush_if,
    output logic          flush_id,
    output logic          err_underflow
);
    state_e       state_q, state_d;
    entry_t       head, push_entry;
    logic         push_acc, pop, mispredict;
    logic         redirect_valid_q, redirect_valid_d, flush_q, flush_d, err_q, err_d;
    logic [W-1:0] redirect_pc_q, redirect_pc_d;
    assign push_ready = state_q == RUN && !full && !stall;
    assign push_acc   = push_valid && push_ready;
    assign pop        = resolve_valid && !stall && !empty && state_q == RUN;
    assign mispredict = pop && resolve_taken != head.pred_taken;
    assign push_entry = '{pred_taken: push_pred_taken, alt_target: W_DEF'(push_alt_target)};
    bq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .push       (push_acc),
        .pop        (pop),
        .clear      (mispredict),
        .push_entry (push_entry),
        .head       (head),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            err_q            <= err_d;
        end
    end
    always_comb begin
        state_d = stall ? state_q :
                  state_q == RUN ? (mispredict ? FLUSH1 : RUN) :
                  state_q == FLUSH1 ? FLUSH2 : RUN;
    end
    // a stalled redirect is held until the PC mux can actually consume it
    always_comb begin
        redirect_valid_d = stall ? redirect_valid_q : mispredict;
        redirect_pc_d    = stall ? redirect_pc_q : mispredict ? W'(head.alt_target) : '0;
        flush_d          = state_d != RUN;
        err_d            = err_q || (resolve_valid && !stall && empty && state_q == RUN);
    end
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_if       = flush_q;
    assign flush_id       = flush_q;
    assign err_underflow  = err_q;
endmodule

// File: tb/tb_branch_target_ctrl.sv
// tb_branch_target_ctrl: directed scoreboard bench for branch_target_ctrl
module tb_branch_target_ctrl;
    import bq_pkg::*;
    localparam int DEPTH = 2;
    localparam int W = 32;
    logic         clk = 0, rst = 0, stall = 0;
    logic         push_valid = 0, push_pred_taken = 0, resolve_valid = 0, resolve_taken = 0;
    logic [W-1:0] push_alt_target = '0;
    logic         push_ready, full, empty, redirect_valid, flush_if, flush_id, err_underflow;
    logic [1:0]   count;
    logic [W-1:0] redirect_pc;
    int           checks = 0, errors = 0;
    typedef struct {
        logic         pred;
        logic [W-1:0] alt;
    } ent_t;
    ent_t         sb[$];
    state_e       mstate = RUN;
    logic         mredir = 0, merr = 0;
    logic [W-1:0] mpc = '0;

    branch_target_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .push_valid      (push_valid),
        .push_pred_taken (push_pred_taken),
        .push_alt_target (push_alt_target),
        .resolve_valid   (resolve_valid),
        .resolve_taken   (resolve_taken),
        .push_ready      (push_ready),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush_if        (flush_if),
        .flush_id        (flush_id),
        .err_underflow   (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".count"}, 64'(count), 64'd0);
        chk({tag, ".empty"}, 64'(empty), 64'd1);
        chk({tag, ".full"}, 64'(full), 64'd0);
        chk({tag, ".redirect_valid"}, 64'(redirect_valid), 64'd0);
        chk({tag, ".redirect_pc"}, 64'(redirect_pc), 64'd0);
        chk({tag, ".flush_if"}, 64'(flush_if), 64'd0);
        chk({tag, ".flush_id"}, 64'(flush_id), 64'd0);
        chk({tag, ".err_underflow"}, 64'(err_underflow), 64'd0);
    endtask

    // one clock of stimulus: scoreboard updated from the drive, DUT compared after the edge
    task automatic cycle(input string tag, input logic pv, input logic pt, input logic [W-1:0] alt,
                         input logic rv, input logic rt, input logic st);
        logic ready, mis;
        ent_t h;
        push_valid = pv;
        push_pred_taken = pt;
        push_alt_target = alt;
        resolve_valid = rv;
        resolve_taken = rt;
        stall = st;
        #1;
        ready = mstate == RUN && sb.size() < DEPTH && !st;
        chk({tag, ".push_ready"}, 64'(push_ready), 64'(ready));
        if (!st) begin
            mis = 1'b0;
            h = '{1'b0, '0};
            if (rv && sb.size() == 0 && mstate == RUN) merr = 1'b1;
            if (rv && sb.size() > 0 && mstate == RUN) begin
                h = sb.pop_front();
                mis = rt != h.pred;
            end
            if (mis) sb.delete();
            else if (pv && ready) sb.push_back('{pt, alt});
            mredir = mis;
            if (mis) mpc = h.alt;
            mstate = mis ? FLUSH1 : (mstate == FLUSH1) ? FLUSH2 : RUN;
        end
        @(posedge clk);
        #1;
        chk({tag, ".count"}, 64'(count), 64'(sb.size()));
        chk({tag, ".empty"}, 64'(empty), 64'(sb.size() == 0));
        chk({tag, ".full"}, 64'(full), 64'(sb.size() == DEPTH));
        chk({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(mredir));
        if (mredir) chk({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(mpc));
        chk({tag, ".flush_if"}, 64'(flush_if), 64'(mstate != RUN));
        chk({tag, ".flush_id"}, 64'(flush_id), 64'(mstate != RUN));
        chk({tag, ".err_underflow"}, 64'(err_underflow), 64'(merr));
    endtask

    initial begin
        #3;
        chk_reset("reset");
        @(negedge clk);
        rst = 1;
        cycle("push0", 1, 0, 'h100, 0, 0, 0);
        cycle("push1", 1, 1, 'h200, 0, 0, 0);
        cycle("push_full", 1, 0, 'h300, 0, 0, 0);
        chk("full.count", 64'(count), 64'd2);
        chk("full.flag", 64'(full), 64'd1);
        cycle("mispredict", 0, 0, '0, 1, 1, 0);
        chk("mispredict.pc", 64'(redirect_pc), 64'h100);
        chk("mispredict.count", 64'(count), 64'd0);
        cycle("flush1_ignore", 1, 1, 'h999, 1, 0, 0);
        cycle("flush2", 0, 0, '0, 0, 0, 0);
        chk("run.flush_if", 64'(flush_if), 64'd0);
        cycle("wrap_fill", 1, 1, 'h400, 0, 0, 0);
        cycle("wrap_pushpop", 1, 0, 'h500, 1, 1, 0);
        chk("wrap.wr_ptr", 64'(dut.u_fifo.wr_ptr_q), 64'd0);
        chk("wrap.count", 64'(count), 64'd1);
        cycle("refill", 1, 1, 'h100, 0, 0, 0);
        cycle("full_pushpop", 1, 0, 'h700, 1, 0, 0);
        chk("full_pushpop.count", 64'(count), 64'd1);
        cycle("stall_mis", 0, 0, '0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle("stalled", 1, 0, 'h55, 1, 1, 1);
        chk("stalled.redirect_valid", 64'(redirect_valid), 64'd1);
        chk("stalled.redirect_pc", 64'(redirect_pc), 64'h100);
        cycle("stall_release", 0, 0, '0, 0, 0, 0);
        chk("stall_release.redirect_valid", 64'(redirect_valid), 64'd0);
        cycle("stall_flush2", 0, 0, '0, 0, 0, 0);
        cycle("underflow", 0, 0, '0, 1, 0, 0);
        cycle("underflow_hold", 0, 0, '0, 0, 0, 0);
        chk("underflow.sticky", 64'(err_underflow), 64'd1);
        cycle("pre_rst_push", 1, 0, 'h800, 0, 0, 0);
        cycle("pre_rst_mis", 0, 0, '0, 1, 1, 0);
        chk("pre_rst.flush_if", 64'(flush_if), 64'd1);
        push_valid = 0;
        resolve_valid = 0;
        stall = 0;
        #2;
        rst = 0;
        #1;
        chk_reset("async_rst");
        sb.delete();
        mstate = RUN;
        mredir = 0;
        merr = 0;
        @(posedge clk);
        #1;
        chk_reset("rst_held");
        @(negedge clk);
        rst = 1;
        cycle("post_rst_push", 1, 1, 'h900, 0, 0, 0);
        chk("post_rst.count", 64'(count), 64'd1);
        cycle("post_rst_pop", 0, 0, '0, 1, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
